// File: rtl/vec_fifo_arbiter_if.sv
// Shared request bus and FIFO write port seen by vec_fifo_arbiter.
// The arbiter uses the slave view; producers and the FIFO side use the master view.
interface vec_fifo_arbiter_if #(
    parameter int WIDTH_VECTOR = 16,
    parameter int N            = 16,
    parameter int NREQ         = 4
);
    logic [NREQ-1:0]                         req_valid;
    logic [NREQ-1:0]                         req_last;
    logic [NREQ-1:0][WIDTH_VECTOR-1:0][N-1:0] req_data;
    logic [NREQ-1:0]                         req_ready;
    logic                                    fifo_full;
    logic                                    fifo_winc;
    logic [WIDTH_VECTOR-1:0][N-1:0]          fifo_wdata;

    modport master (
        output req_valid, req_last, req_data, fifo_full,
        input  req_ready, fifo_winc, fifo_wdata
    );

    modport slave (
        input  req_valid, req_last, req_data, fifo_full,
        output req_ready, fifo_winc, fifo_wdata
    );
endinterface

// File: rtl/vec_fifo_arbiter.sv
// Round-robin arbiter sharing one vector FIFO write port among NREQ producers.
// Bursts are written contiguously; a watchdog cuts bursts longer than MAX_BURST beats.
module vec_fifo_arbiter #(
    parameter int WIDTH_VECTOR = 16,
    parameter int N            = 16,
    parameter int NREQ         = 4,
    parameter int MAX_BURST    = 64,
    localparam int GW          = $clog2(NREQ),
    localparam int BW          = $clog2(MAX_BURST + 1)
) (
    input  logic                clk,
    input  logic                rst,
    vec_fifo_arbiter_if.slave   bus,
    output logic                busy,
    output logic [GW-1:0]       grant_id,
    output logic                burst_err,
    output logic [31:0]         beat_cnt
);

    typedef enum logic {IDLE, LOCK} state_t;

    state_t        state;
    logic [BW-1:0] burst_cnt;
    logic [GW-1:0] sel;
    logic [GW-1:0] cand;
    logic          found;
    logic          xfer;

    assign xfer           = bus.req_valid[grant_id] & ~bus.fifo_full;
    assign bus.fifo_winc  = busy & xfer;
    assign bus.fifo_wdata = bus.req_data[grant_id];

    always_comb begin
        bus.req_ready = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            bus.req_ready[i] = busy & (grant_id == GW'(i)) & ~bus.fifo_full;
        end
    end

    // Search starts one past the last grant, so the previous winner has lowest priority.
    always_comb begin
        found = 1'b0;
        sel   = grant_id;
        cand  = '0;
        for (int unsigned k = 1; k <= NREQ; k++) begin
            cand = GW'((32'(grant_id) + k) % NREQ);
            if (!found && bus.req_valid[cand]) begin
                sel   = cand;
                found = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            busy      <= 1'b0;
            grant_id  <= GW'(NREQ - 1);
            burst_err <= 1'b0;
            beat_cnt  <= '0;
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (found) begin
                        grant_id  <= sel;
                        burst_cnt <= '0;
                        state     <= LOCK;
                        busy      <= 1'b1;
                    end
                end
                LOCK: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        beat_cnt  <= beat_cnt + 32'd1;
                        if (bus.req_last[grant_id]) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (burst_cnt == BW'(MAX_BURST - 1)) begin
                            state     <= IDLE;
                            busy      <= 1'b0;
                            burst_err <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vec_fifo_arbiter.sv
// Directed bench for vec_fifo_arbiter: burst transfer, round-robin order,
// backpressure, watchdog release, mid-burst reset and producer bubbles.
module tb_vec_fifo_arbiter;

    localparam int WV = 16;
    localparam int NB = 16;
    localparam int NR = 4;
    localparam int MB = 64;
    localparam int DW = WV * NB;

    logic        clk;
    logic        rst;
    logic        busy;
    logic [1:0]  grant_id;
    logic        burst_err;
    logic [31:0] beat_cnt;

    int total = 0;
    int bad   = 0;

    // Producer model state
    int unsigned rem [NR];
    int unsigned nb  [NR];
    int unsigned blen[NR];
    int unsigned seq [NR];
    bit          uselast[NR];
    bit          hold[NR];

    vec_fifo_arbiter_if #(.WIDTH_VECTOR(WV), .N(NB), .NREQ(NR)) bus ();

    vec_fifo_arbiter #(
        .WIDTH_VECTOR(WV),
        .N(NB),
        .NREQ(NR),
        .MAX_BURST(MB)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave),
        .busy(busy),
        .grant_id(grant_id),
        .burst_err(burst_err),
        .beat_cnt(beat_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] pat(int r, int b);
        logic [NB-1:0] lane;
        lane = {r[3:0], b[11:0]};
        return {WV{lane}};
    endfunction

    task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_data(string tag, logic [DW-1:0] obs, logic [DW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic refresh(int r);
        if (rem[r] == 0 && nb[r] > 0) begin
            rem[r] = blen[r];
            nb[r]--;
        end
        bus.req_valid[r] = (rem[r] > 0) && !hold[r];
        bus.req_last[r]  = uselast[r] && (rem[r] == 1);
        bus.req_data[r]  = pat(r, int'(seq[r]));
    endtask

    task automatic clear_producers();
        for (int r = 0; r < NR; r++) begin
            rem[r] = 0; nb[r] = 0; blen[r] = 0; seq[r] = 0;
            uselast[r] = 1'b1; hold[r] = 1'b0;
            refresh(r);
        end
    endtask

    task automatic start(int r, int unsigned len, int unsigned bursts, bit with_last);
        blen[r] = len; nb[r] = bursts; uselast[r] = with_last;
        refresh(r);
    endtask

    // One clock: acceptance is decided by what the DUT shows just before the edge.
    task automatic cyc();
        logic [NR-1:0] acc;
        @(negedge clk);
        acc = bus.req_ready & bus.req_valid;
        @(posedge clk);
        #1;
        for (int r = 0; r < NR; r++) begin
            if (acc[r]) begin
                seq[r]++;
                rem[r]--;
            end
            refresh(r);
        end
        #1;
    endtask

    task automatic expect_write(string tag, int r, int b);
        logic [NR-1:0] one;
        one = '0;
        one[r] = 1'b1;
        chk({tag, "/busy"}, 64'(busy), 64'd1);
        chk({tag, "/grant"}, 64'(grant_id), 64'(r));
        chk({tag, "/winc"}, 64'(bus.fifo_winc), 64'd1);
        chk({tag, "/ready"}, 64'(bus.req_ready), 64'(one));
        chk_data({tag, "/wdata"}, bus.fifo_wdata, pat(r, b));
    endtask

    task automatic expect_idle(string tag, int g);
        chk({tag, "/busy"}, 64'(busy), 64'd0);
        chk({tag, "/winc"}, 64'(bus.fifo_winc), 64'd0);
        chk({tag, "/ready"}, 64'(bus.req_ready), 64'd0);
        chk({tag, "/grant"}, 64'(grant_id), 64'(g));
    endtask

    task automatic expect_stall(string tag, int g);
        chk({tag, "/busy"}, 64'(busy), 64'd1);
        chk({tag, "/winc"}, 64'(bus.fifo_winc), 64'd0);
        chk({tag, "/grant"}, 64'(grant_id), 64'(g));
    endtask

    int order[5] = '{0, 1, 2, 3, 0};
    int first[5] = '{0, 0, 0, 0, 2};

    initial begin
        rst = 1'b1;
        bus.fifo_full = 1'b0;
        clear_producers();
        #7;
        // Reset values
        expect_idle("reset", 3);
        chk("reset/burst_err", 64'(burst_err), 64'd0);
        chk("reset/beat_cnt", 64'(beat_cnt), 64'd0);

        // Requester 2 alone, 3-beat burst
        rst = 1'b0;
        start(2, 3, 1, 1'b1);
        #1;
        chk("t1/busy_pre", 64'(busy), 64'd0);
        cyc(); expect_write("t1b0", 2, 0);
        cyc(); expect_write("t1b1", 2, 1);
        cyc(); expect_write("t1b2", 2, 2);
        cyc(); expect_idle("t1end", 2);
        chk("t1/beat_cnt", 64'(beat_cnt), 64'd3);

        // All requesters valid, 2-beat bursts: order 0,1,2,3,0
        rst = 1'b1;
        #1;
        rst = 1'b0;
        clear_producers();
        start(0, 2, 2, 1'b1);
        start(1, 2, 1, 1'b1);
        start(2, 2, 1, 1'b1);
        start(3, 2, 1, 1'b1);
        #1;
        expect_idle("t2start", 3);
        for (int j = 0; j < 5; j++) begin
            cyc(); expect_write("t2a", order[j], first[j]);
            cyc(); expect_write("t2b", order[j], first[j] + 1);
            cyc(); expect_idle("t2gap", order[j]);
        end
        chk("t2/beat_cnt", 64'(beat_cnt), 64'd10);

        // fifo_full during LOCK cycles 2..4 of a 5-beat burst from requester 1
        clear_producers();
        start(1, 5, 1, 1'b1);
        cyc(); expect_write("t3b0", 1, 0);
        cyc();
        bus.fifo_full = 1'b1;
        for (int k = 0; k < 3; k++) begin
            #1;
            expect_stall("t3stall", 1);
            chk("t3stall/ready", 64'(bus.req_ready), 64'd0);
            if (k < 2) cyc();
        end
        cyc();
        bus.fifo_full = 1'b0;
        #1;
        expect_write("t3b1", 1, 1);
        for (int b = 2; b < 5; b++) begin
            cyc(); expect_write("t3bn", 1, b);
        end
        cyc(); expect_idle("t3end", 1);
        chk("t3/beat_cnt", 64'(beat_cnt), 64'd15);

        // Watchdog: requester 0 never asserts last
        clear_producers();
        start(0, 70, 1, 1'b0);
        #1;
        cyc();
        for (int k = 1; k <= 64; k++) begin
            expect_write("t4beat", 0, k - 1);
            chk("t4/err_low", 64'(burst_err), 64'd0);
            if (k == 1) begin
                start(2, 1, 1, 1'b1);
                start(3, 1, 1, 1'b1);
            end
            cyc();
        end
        expect_idle("t4cut", 0);
        chk("t4/burst_err", 64'(burst_err), 64'd1);
        chk("t4/beat_cnt", 64'(beat_cnt), 64'd79);
        cyc(); expect_write("t4r2", 2, 0);
        cyc(); expect_idle("t4g2", 2);
        cyc(); expect_write("t4r3", 3, 0);
        cyc(); expect_idle("t4g3", 3);
        chk("t4/beat_cnt2", 64'(beat_cnt), 64'd81);
        cyc(); expect_write("t4r0a", 0, 64);
        chk("t4/err_sticky", 64'(burst_err), 64'd1);
        cyc(); expect_write("t4r0b", 0, 65);
        cyc(); expect_write("t4r0c", 0, 66);

        // Reset during the 3rd beat of requester 0's burst
        rst = 1'b1;
        #1;
        expect_idle("t5rst", 3);
        chk("t5/burst_err", 64'(burst_err), 64'd0);
        chk("t5/beat_cnt", 64'(beat_cnt), 64'd0);
        rst = 1'b0;
        clear_producers();
        start(0, 2, 1, 1'b1);
        start(1, 1, 1, 1'b1);
        cyc(); expect_write("t5b0", 0, 0);
        cyc(); expect_write("t5b1", 0, 1);
        cyc(); expect_idle("t5gap", 0);
        cyc(); expect_write("t5r1", 1, 0);
        cyc(); expect_idle("t5end", 1);
        chk("t5/beat_cnt", 64'(beat_cnt), 64'd3);

        // Requester 3 bubbles for 5 cycles while requester 0 waits
        clear_producers();
        start(3, 4, 1, 1'b1);
        start(0, 1, 1, 1'b1);
        #1;
        cyc(); expect_write("t6b0", 3, 0);
        cyc(); expect_write("t6b1", 3, 1);
        cyc();
        hold[3] = 1'b1;
        refresh(3);
        for (int k = 0; k < 5; k++) begin
            #1;
            expect_stall("t6bubble", 3);
            chk("t6bubble/ready", 64'(bus.req_ready), 64'd8);
            cyc();
        end
        hold[3] = 1'b0;
        refresh(3);
        #1;
        expect_write("t6b2", 3, 2);
        cyc(); expect_write("t6b3", 3, 3);
        cyc(); expect_idle("t6gap", 3);
        cyc(); expect_write("t6r0", 0, 0);
        cyc(); expect_idle("t6end", 0);
        chk("t6/beat_cnt", 64'(beat_cnt), 64'd8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/vec_fifo_arbiter.md
# vec_fifo_arbiter

Round-robin write-port arbiter in front of the core's input vector FIFO. It shares the single FIFO write port (`fifo_wdata`/`fifo_winc`/`fifo_full`) among NREQ vector producers. Each producer's burst, terminated by `req_last`, is written contiguously without interleaving. A watchdog forces release of any burst longer than MAX_BURST beats. The block sits in the FIFO write clock domain, between the producers and the core's `fifo_w*` port.

## Interface
- `WIDTH_VECTOR`, 16: lanes per vector (power of 2).
- `N`, 16: bits per lane.
- `NREQ`, 4: number of requesters, ≥2.
- `MAX_BURST`, 64: maximum beats per grant, ≥1.
- `clk`  in  1  FIFO write clock (the core's `fifo_wclk` domain); single clock.
- `rst`  in  1  reset, asynchronous assert, active-high.
- `req_valid`  in  NREQ  requester i offers a beat.
- `req_last`  in  NREQ  beat is the last of requester i's burst.
- `req_data`  in  NREQ×WIDTH_VECTOR×N (packed [NREQ-1:0][WIDTH_VECTOR-1:0][N-1:0])  beat data.
- `req_ready`  out  NREQ  beat of requester i accepted this cycle.
- `fifo_full`  in  1  core input FIFO full.
- `fifo_winc`  out  1  write strobe to FIFO.
- `fifo_wdata`  out  WIDTH_VECTOR×N  write data to FIFO.
- `busy`  out  1  a grant is held (state LOCK).
- `grant_id`  out  $clog2(NREQ)  index of the current or last granted requester.
- `burst_err`  out  1  sticky: a burst was cut by the watchdog.
- `beat_cnt`  out  32  total beats written since reset, wraps.

## Operation
- The FSM has two states: IDLE and LOCK.
- **IDLE**
  - If any `req_valid` is high, select the first valid index in round-robin order starting at `grant_id+1` (mod NREQ).
  - Register the selection into `grant_id`, clear `burst_cnt`, and go to LOCK.
  - If no `req_valid` is high, stay in IDLE.
- **LOCK**
  - Transfer condition: `xfer = req_valid[grant_id] & ~fifo_full`.
  - On `xfer`, `burst_cnt` increments and `beat_cnt` increments.
  - Leave for IDLE when `xfer & req_last[grant_id]` is true.
  - Also leave for IDLE when `xfer & (burst_cnt == MAX_BURST-1)` is true and `req_last` is low. In that case set `burst_err` to 1; it stays set until `rst`.
  - When `req_valid[grant_id]` is low, remain in LOCK. The grant is held across producer bubbles; there is no timeout on idleness.
- Combinational outputs:
  - `fifo_winc = busy & xfer`.
  - `req_ready[i] = busy & (grant_id == i) & ~fifo_full`.
  - `fifo_wdata = req_data[grant_id]`, driven at all times.
- Non-granted requesters see `req_ready = 0` and must hold `valid`, `data` and `last` stable until accepted.
- `burst_cnt` is an internal $clog2(MAX_BURST+1)-bit counter. `beat_cnt` is 32 bits and wraps 2^32-1 → 0.

## Timing
- Reset values (asynchronous, on `rst` high):
  - state = IDLE, `busy` = 0, `grant_id` = NREQ-1 (so requester 0 wins first).
  - `burst_err` = 0, `beat_cnt` = 0, `burst_cnt` = 0.
  - `fifo_winc` = 0 and `req_ready` = 0 immediately.
- Arbitration latency:
  - A `req_valid` seen in IDLE at edge k gives LOCK and `busy` = 1 after edge k.
  - The first write can occur in cycle k+1 if `fifo_full` = 0.
- Throughput in LOCK is one beat per cycle while valid and not full. `fifo_full` gates `fifo_winc` in the same cycle (zero-latency backpressure).
- Between bursts there is exactly one IDLE bubble cycle, even when another requester is already waiting.
- Single-beat burst (`req_last` on the first beat): LOCK lasts 1 cycle, then IDLE.
- Reset mid-burst: `fifo_winc` drops asynchronously and the burst is abandoned. Producers restart their bursts after reset.
- `fifo_full` rising mid-burst stalls the burst; `grant_id` is unchanged.

## Test plan
- Reset release, requester 2 valid alone with a 3-beat burst (last on beat 3), FIFO not full:
  - `busy` rises 1 cycle after valid.
  - 3 consecutive `fifo_winc` with `req_data[2]` values.
  - `busy` falls, `grant_id` = 2, `beat_cnt` = 3.
- All 4 requesters continuously valid, each with 2-beat bursts:
  - Grant order 0,1,2,3,0.
  - Each burst is 2 writes followed by 1 idle cycle.
  - `beat_cnt` = 10 after 5 bursts.
- `fifo_full` high for cycles 2–4 of a 5-beat burst from requester 1:
  - `fifo_winc` and `req_ready[1]` are 0 during those cycles.
  - All 5 beats are written in order and there is no regrant.
- Requester 0 bursts with no `req_last` for 70 beats, MAX_BURST = 64:
  - Release happens after beat 64 and `burst_err` = 1.
  - Requester 0 is regranted only after the other valid requesters are served.
- `rst` pulsed in the 3rd beat of a burst:
  - `fifo_winc`, `busy` and `burst_err` go to 0 at once, and `grant_id` = 3.
  - The next grant goes to requester 0 if valid.
- Requester 3 bubbles `req_valid` low for 5 cycles mid-burst while requester 0 is valid:
  - The grant stays at 3 with no writes during the bubble.
  - Requester 0 is granted only after requester 3's last beat.
